game_leds_out_pio: RTL and testbench

- Avalon-MM slave output PIO that drives the board LEDs from the Nios software.
- It is the write-direction counterpart of the switch input PIO on the same system interconnect.
- Provides a read/write data register, atomic bit-set and bit-clear strobes, and readback of every writable register.
- An optional hardware blink engine toggles selected LEDs at a programmable rate, with no CPU involvement.

---
 rtl/game_leds_out_pio.sv | 161 ++++++++++++++++
 tb/tb_game_leds_out_pio.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/game_leds_out_pio.sv
// Avalon-MM output PIO driving the board LEDs: data register with atomic set/clear strobes.
// Define GAME_LEDS_BLINK_EN to add the per-bit hardware blink engine (mask, period, prescaler, phase).
module game_leds_out_pio #(
    parameter int unsigned WIDTH        = 18,
    parameter logic [31:0] RESET_VALUE  = 32'h0000_0000,
    parameter int unsigned PERIOD_W     = 26,
    parameter logic [31:0] RESET_PERIOD = 32'd25000000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_MASK   = 3'd1;
    localparam logic [2:0] ADDR_PERIOD = 3'd2;
    localparam logic [2:0] ADDR_SET    = 3'd4;
    localparam logic [2:0] ADDR_CLEAR  = 3'd5;

    logic             wr_s;
    logic [WIDTH-1:0] wd_s;
    logic [WIDTH-1:0] data_r;
    logic [WIDTH-1:0] data_nxt_s;
    logic [WIDTH-1:0] out_nxt_s;
    logic [31:0]      rd_nxt_s;
    logic [31:0]      readdata_r;
    logic [WIDTH-1:0] out_port_r;
    logic             unused_wd_s;

    assign wr_s        = chipselect & ~write_n;
    assign wd_s        = writedata[WIDTH-1:0];
    assign unused_wd_s = ^writedata;

    // Next data value: plain write, or set/clear applied to the current value.
    always_comb begin
        data_nxt_s = data_r;
        if (wr_s) begin
            case (address)
                ADDR_DATA:  data_nxt_s = wd_s;
                ADDR_SET:   data_nxt_s = data_r | wd_s;
                ADDR_CLEAR: data_nxt_s = data_r & ~wd_s;
                default:    data_nxt_s = data_r;
            endcase
        end else begin
            data_nxt_s = data_r;
        end
    end

`ifdef GAME_LEDS_BLINK_EN
    logic [WIDTH-1:0]    mask_r;
    logic [WIDTH-1:0]    mask_nxt_s;
    logic [PERIOD_W-1:0] period_r;
    logic [PERIOD_W-1:0] period_nxt_s;
    logic [PERIOD_W-1:0] count_r;
    logic [PERIOD_W-1:0] count_nxt_s;
    logic                phase_r;
    logic                phase_nxt_s;
    logic [PERIOD_W-1:0] wd_period_s;

    assign wd_period_s = writedata[PERIOD_W-1:0];

    // Mask and period register writes.
    always_comb begin
        mask_nxt_s   = mask_r;
        period_nxt_s = period_r;
        if (wr_s && (address == ADDR_MASK)) begin
            mask_nxt_s = wd_s;
        end else begin
            mask_nxt_s = mask_r;
        end
        if (wr_s && (address == ADDR_PERIOD)) begin
            period_nxt_s = wd_period_s;
        end else begin
            period_nxt_s = period_r;
        end
    end

    // Prescaler: a period write restarts in phase 0; compare against zero only, so no wrap hazard.
    always_comb begin
        count_nxt_s = count_r;
        phase_nxt_s = phase_r;
        if (wr_s && (address == ADDR_PERIOD)) begin
            count_nxt_s = wd_period_s;
            phase_nxt_s = 1'b0;
        end else if (period_r == {PERIOD_W{1'b0}}) begin
            count_nxt_s = {PERIOD_W{1'b0}};
            phase_nxt_s = 1'b0;
        end else if (count_r == {PERIOD_W{1'b0}}) begin
            count_nxt_s = period_r;
            phase_nxt_s = ~phase_r;
        end else begin
            count_nxt_s = count_r - PERIOD_W'(1);
            phase_nxt_s = phase_r;
        end
    end

    // Blink engine state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_r   <= {WIDTH{1'b0}};
            period_r <= RESET_PERIOD[PERIOD_W-1:0];
            count_r  <= RESET_PERIOD[PERIOD_W-1:0];
            phase_r  <= 1'b0;
        end else begin
            mask_r   <= mask_nxt_s;
            period_r <= period_nxt_s;
            count_r  <= count_nxt_s;
            phase_r  <= phase_nxt_s;
        end
    end

    assign out_nxt_s = data_r ^ (mask_r & {WIDTH{phase_r}});

    // Read mux including the blink registers; set/clear and reserved addresses read zero.
    always_comb begin
        rd_nxt_s = 32'h0000_0000;
        case (address)
            ADDR_DATA:   rd_nxt_s = 32'(data_r);
            ADDR_MASK:   rd_nxt_s = 32'(mask_r);
            ADDR_PERIOD: rd_nxt_s = 32'(period_r);
            default:     rd_nxt_s = 32'h0000_0000;
        endcase
    end
`else
    logic [PERIOD_W-1:0] unused_period_s;

    assign unused_period_s = RESET_PERIOD[PERIOD_W-1:0];
    assign out_nxt_s       = data_r;

    // Read mux without blink registers; only the data register reads non-zero.
    always_comb begin
        rd_nxt_s = 32'h0000_0000;
        case (address)
            ADDR_DATA: rd_nxt_s = 32'(data_r);
            default:   rd_nxt_s = 32'h0000_0000;
        endcase
    end
`endif

    // Data, registered LED drive and registered read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_r     <= RESET_VALUE[WIDTH-1:0];
            out_port_r <= RESET_VALUE[WIDTH-1:0];
            readdata_r <= 32'h0000_0000;
        end else begin
            data_r     <= data_nxt_s;
            out_port_r <= out_nxt_s;
            readdata_r <= rd_nxt_s;
        end
    end

    assign out_port = out_port_r;
    assign readdata = readdata_r;

endmodule

// File: tb/tb_game_leds_out_pio.sv
// Directed self-checking bench for game_leds_out_pio (RESET_VALUE = 0x15).
// Blink checks are compiled in only when GAME_LEDS_BLINK_EN is defined.
module tb_game_leds_out_pio;

    localparam int unsigned W = 18;

    logic         clk;
    logic         reset_n;
    logic [2:0]   address;
    logic         chipselect;
    logic         write_n;
    logic [31:0]  writedata;
    logic [31:0]  readdata;
    logic [W-1:0] out_port;

    int n_checks;
    int n_pass;

    game_leds_out_pio #(
        .WIDTH       (W),
        .RESET_VALUE (32'h0000_0015),
        .PERIOD_W    (26),
        .RESET_PERIOD(32'd25000000)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
    endtask

    task automatic bus_idle();
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // Returns one cycle after the write commits, so out_port already reflects it.
    task automatic write_reg(input logic [2:0] a, input logic [31:0] d);
        drive_wr(a, d);
        bus_idle();
        @(negedge clk);
    endtask

    task automatic read_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
        @(negedge clk);
        address = a;
        @(negedge clk);
        check_eq(tag, readdata, exp);
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0000_0000;

        repeat (3) @(negedge clk);
        check_eq("rst_out", 32'(out_port), 32'h0000_0015);
        check_eq("rst_rd", readdata, 32'h0000_0000);
        reset_n = 1'b1;
        #1;
        check_eq("rel_rd", readdata, 32'h0000_0000);
        read_check("rd_data_rst", 3'd0, 32'h0000_0015);

        write_reg(3'd0, 32'hFFFF_FFFF);
        check_eq("wr_all_ones", 32'(out_port), 32'h0003_FFFF);
        read_check("rd_data_ones", 3'd0, 32'h0003_FFFF);
        write_reg(3'd5, 32'h0000_000F);
        check_eq("clear_f", 32'(out_port), 32'h0003_FFF0);
        write_reg(3'd4, 32'h0000_0003);
        check_eq("set_3", 32'(out_port), 32'h0003_FFF3);
        read_check("rd_set_addr", 3'd4, 32'h0000_0000);
        read_check("rd_clr_addr", 3'd5, 32'h0000_0000);

        // Write strobe without chipselect must be ignored.
        @(negedge clk);
        address    = 3'd0;
        writedata  = 32'h0000_0000;
        chipselect = 1'b0;
        write_n    = 1'b0;
        @(negedge clk);
        write_n = 1'b1;
        @(negedge clk);
        check_eq("no_cs", 32'(out_port), 32'h0003_FFF3);

        write_reg(3'd7, 32'hFFFF_FFFF);
        check_eq("rsvd_wr_out", 32'(out_port), 32'h0003_FFF3);
        read_check("rd_rsvd7", 3'd7, 32'h0000_0000);
        read_check("rd_data_after7", 3'd0, 32'h0003_FFF3);

        write_reg(3'd4, 32'h0000_0000);
        check_eq("set_zero", 32'(out_port), 32'h0003_FFF3);
        write_reg(3'd5, 32'h0000_0000);
        check_eq("clr_zero", 32'(out_port), 32'h0003_FFF3);

        // Back-to-back set then clear on consecutive edges.
        drive_wr(3'd4, 32'h0000_000C);
        drive_wr(3'd5, 32'h0000_0003);
        bus_idle();
        @(negedge clk);
        check_eq("b2b_set_clr", 32'(out_port), 32'h0003_FFFC);

        // Read during write returns the old value, new value one cycle later.
        drive_wr(3'd0, 32'h0000_AAAA);
        bus_idle();
        check_eq("rdw_old", readdata, 32'h0003_FFFC);
        @(negedge clk);
        check_eq("rdw_new", readdata, 32'h0000_AAAA);

`ifdef GAME_LEDS_BLINK_EN
        write_reg(3'd0, 32'h0000_0000);
        write_reg(3'd1, 32'h0000_0001);
        read_check("rd_mask", 3'd1, 32'h0000_0001);
        write_reg(3'd2, 32'h0000_0003);
        for (int k = 1; k <= 12; k++) begin
            check_eq($sformatf("blink4_k%0d", k), 32'(out_port[0]), 32'(((k - 1) / 4) % 2));
            @(negedge clk);
        end
        read_check("rd_period", 3'd2, 32'h0000_0003);

        write_reg(3'd2, 32'h0000_0000);
        for (int k = 0; k < 6; k++) begin
            check_eq($sformatf("period0_k%0d", k), 32'(out_port[0]), 32'h0000_0000);
            @(negedge clk);
        end

        // Restart while phase is high: period write forces phase back to 0.
        write_reg(3'd2, 32'h0000_0003);
        repeat (3) @(negedge clk);
        write_reg(3'd2, 32'h0000_0002);
        for (int k = 1; k <= 9; k++) begin
            check_eq($sformatf("blink3_k%0d", k), 32'(out_port[0]), 32'(((k - 1) / 3) % 2));
            @(negedge clk);
        end

        begin
            int waited;
            waited = 0;
            while ((out_port[0] !== 1'b1) && (waited < 10)) begin
                @(negedge clk);
                waited++;
            end
            check_eq("wait_phase_high", 32'(out_port[0]), 32'h0000_0001);
        end
`else
        write_reg(3'd1, 32'hFFFF_FFFF);
        write_reg(3'd2, 32'h0000_0005);
        read_check("rd_mask_absent", 3'd1, 32'h0000_0000);
        read_check("rd_period_absent", 3'd2, 32'h0000_0000);
        check_eq("out_no_blink", 32'(out_port), 32'h0000_AAAA);
`endif

        // Asynchronous reset in mid-cycle.
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_rst_out", 32'(out_port), 32'h0000_0015);
        check_eq("async_rst_rd", readdata, 32'h0000_0000);
        @(negedge clk);
        reset_n = 1'b1;
        read_check("rd_data_rst2", 3'd0, 32'h0000_0015);
`ifdef GAME_LEDS_BLINK_EN
        read_check("rd_mask_rst2", 3'd1, 32'h0000_0000);
        read_check("rd_period_rst2", 3'd2, 32'd25000000);
        repeat (4) @(negedge clk);
`endif
        check_eq("out_after_rst2", 32'(out_port), 32'h0000_0015);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
